// File: rtl/tx_logic.sv
// tx_logic: output stage that drains one router FIFO and hands each item to
// one of PORT_COUNT downstream receivers over per-port two-phase req/ack.
// The destination port is carried in the top PORT_BITS bits of every item.
// One item is in flight at a time and items are never reordered.
// Optional feature macro: TX_ACK_SYNC_EN -- when defined, every tx_ack bit
// goes through a two-flop synchronizer before it is compared with tx_req,
// for receivers that live in another clock domain.
module tx_logic #(
   parameter int ID         = -1,
   parameter int SIZE       = 8,
   parameter int PORT_COUNT = 5,
   parameter int PORT_BITS  = 3
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         fifo_read,
   input  logic                         fifo_empty,
   input  logic [SIZE-1:0]              fifo_item_out,
   output logic [PORT_COUNT-1:0]        tx_req,
   input  logic [PORT_COUNT-1:0]        tx_ack,
   output logic [SIZE*PORT_COUNT-1:0]   tx_data,
   output logic [7:0]                   drop_count,
   output logic                         busy
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] READ     = 2'd1;
   localparam logic [1:0] LATCH    = 2'd2;
   localparam logic [1:0] WAIT_ACK = 2'd3;

   // The port field must be wide enough to address every output port.
   if ((2 ** PORT_BITS) < PORT_COUNT) begin : g_bad_cfg
      $error("tx_logic %0d: PORT_BITS too narrow for PORT_COUNT", ID);
   end

   logic [1:0]                  state_q,      state_d;
   logic                        fifo_read_q,  fifo_read_d;
   logic [PORT_COUNT-1:0]       tx_req_q,     tx_req_d;
   logic [SIZE*PORT_COUNT-1:0]  tx_data_q,    tx_data_d;
   logic [7:0]                  drop_count_q, drop_count_d;
   logic                        busy_q,       busy_d;
   logic [SIZE-1:0]             item_q,       item_d;
   logic                        item_held_q,  item_held_d;
   logic [PORT_COUNT-1:0]       port_sel_q,   port_sel_d;

   logic [PORT_COUNT-1:0]       ack_eff;
   logic [PORT_COUNT-1:0]       pending;
   logic [SIZE-1:0]             cur_item;
   logic [PORT_BITS-1:0]        cur_port;
   logic [PORT_COUNT-1:0]       port_hot;
   logic                        port_ok;
   logic                        port_free;

`ifdef TX_ACK_SYNC_EN
   logic [PORT_COUNT-1:0] ack_meta_q;
   logic [PORT_COUNT-1:0] ack_sync_q;

   // Two-flop synchronizer bringing the receivers' ack toggles into clk.
   always_ff @(posedge clk) begin
      if (reset) begin
         ack_meta_q <= '0;
         ack_sync_q <= '0;
      end else begin
         ack_meta_q <= tx_ack;
         ack_sync_q <= ack_meta_q;
      end
   end

   assign ack_eff = ack_sync_q;
`else
   assign ack_eff = tx_ack;
`endif

   // A port is pending while its request and acknowledge phases differ.
   assign pending = tx_req_q ^ ack_eff;

   // The head item is only guaranteed on the first LATCH cycle, so a held
   // copy is used if LATCH has to wait for the destination port.
   assign cur_item = item_held_q ? item_q : fifo_item_out;
   assign cur_port = cur_item[SIZE-1 -: PORT_BITS];

   // One-hot decode of the destination; all-zero means the port is invalid.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // otherwise an unassigned path infers a latch.
      port_hot = '0;
      for (int k = 0; k < PORT_COUNT; k++) begin
         port_hot[k] = (32'(cur_port) == k);
      end
   end

   assign port_ok   = |port_hot;
   assign port_free = ~|(port_hot & pending);

   // Next-state and registered-output logic for the drain FSM.
   always_comb begin
      state_d      = state_q;
      fifo_read_d  = 1'b0;
      tx_req_d     = tx_req_q;
      tx_data_d    = tx_data_q;
      drop_count_d = drop_count_q;
      item_d       = item_q;
      item_held_d  = item_held_q;
      port_sel_d   = port_sel_q;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d     = READ;
               fifo_read_d = 1'b1;
            end
         end

         READ: begin
            state_d = LATCH;
         end

         LATCH: begin
            item_d      = cur_item;
            item_held_d = 1'b1;
            if (!port_ok) begin
               if (drop_count_q != 8'hFF) begin
                  drop_count_d = drop_count_q + 8'd1;
               end
               item_held_d = 1'b0;
               state_d     = IDLE;
            end else if (port_free) begin
               tx_req_d = tx_req_q ^ port_hot;
               for (int k = 0; k < PORT_COUNT; k++) begin
                  if (port_hot[k]) begin
                     tx_data_d[k*SIZE +: SIZE] = cur_item;
                  end
               end
               port_sel_d  = port_hot;
               item_held_d = 1'b0;
               state_d     = WAIT_ACK;
            end
         end

         WAIT_ACK: begin
            // Only the port that carries the current item can release us.
            if ((port_sel_q & pending) == '0) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   // Control and output registers, cleared by the synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge value of its inputs.
      if (reset) begin
         state_q      <= IDLE;
         fifo_read_q  <= 1'b0;
         tx_req_q     <= '0;
         tx_data_q    <= '0;
         drop_count_q <= '0;
         busy_q       <= 1'b0;
         item_held_q  <= 1'b0;
         port_sel_q   <= '0;
      end else begin
         state_q      <= state_d;
         fifo_read_q  <= fifo_read_d;
         tx_req_q     <= tx_req_d;
         tx_data_q    <= tx_data_d;
         drop_count_q <= drop_count_d;
         busy_q       <= busy_d;
         item_held_q  <= item_held_d;
         port_sel_q   <= port_sel_d;
      end
   end

   // Holding copy of the item while LATCH waits for its port.
   always_ff @(posedge clk) begin
      // NOTE: this data register is left out of reset on purpose; it is only
      // read while item_held_q is set, and that flag is reset.
      item_q <= item_d;
   end

   assign fifo_read  = fifo_read_q;
   assign tx_req     = tx_req_q;
   assign tx_data    = tx_data_q;
   assign drop_count = drop_count_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_tx_logic.sv
// tb_tx_logic: self-checking bench for tx_logic. A queue-based FIFO feeds
// the DUT, per-port receivers answer the two-phase handshake (randomly or on
// command), and a monitor compares every send against a scoreboard of the
// items the stimulus pushed, plus a per-port picture of tx_data.
module tb_tx_logic;

   localparam int SIZE = 8;
   localparam int PC   = 5;
   localparam int PB   = 3;
`ifdef TX_ACK_SYNC_EN
   localparam int ACK_LAT = 3;
`else
   localparam int ACK_LAT = 1;
`endif

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               fifo_read;
   logic               fifo_empty = 1'b1;
   logic [SIZE-1:0]    fifo_item_out = '0;
   logic [PC-1:0]      tx_req;
   logic [PC-1:0]      tx_ack = '0;
   logic [SIZE*PC-1:0] tx_data;
   logic [7:0]         drop_count;
   logic               busy;

   logic [7:0]    fifo_mem[$];
   logic [7:0]    exp_q[$];
   logic [7:0]    exp_slice[PC];
   int            drop_model = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   bit            auto_ack = 1'b0;
   logic [PC-1:0] man_req = '0;
   logic [PC-1:0] man_seen = '0;
   int            dly[PC];
   logic [PC-1:0] prev_req = '0;
   logic          prev_rd = 1'b0;

   tx_logic #(.ID(7), .SIZE(SIZE), .PORT_COUNT(PC), .PORT_BITS(PB)) dut (
      .clk           (clk),
      .reset         (reset),
      .fifo_read     (fifo_read),
      .fifo_empty    (fifo_empty),
      .fifo_item_out (fifo_item_out),
      .tx_req        (tx_req),
      .tx_ack        (tx_ack),
      .tx_data       (tx_data),
      .drop_count    (drop_count),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Push into the FIFO and record what the specification says must follow.
   task automatic push_item(input logic [7:0] it);
      fifo_mem.push_back(it);
      if (32'(it[7:5]) < PC) exp_q.push_back(it);
      else if (drop_model < 255) drop_model++;
   endtask

   task automatic ack_port(input int k);
      man_req[k] = ~man_req[k];
   endtask

   task automatic wait_idle(input int budget);
      int stable = 0;
      for (int i = 0; i < budget && stable < 3; i++) begin
         tick();
         if (fifo_mem.size() == 0 && exp_q.size() == 0 && !busy && tx_req == tx_ack) stable++;
         else stable = 0;
      end
      check("idle_reached", 64'(stable >= 3), 64'd1);
   endtask

   // FIFO model: pop on fifo_read, head item valid the following cycle.
   always @(posedge clk) begin
      if (fifo_read && fifo_mem.size() > 0) fifo_item_out <= fifo_mem.pop_front();
   end

   always @(negedge clk) begin
      fifo_empty = (fifo_mem.size() == 0);
   end

   // Receivers: commanded toggles first, otherwise random-latency auto ack.
   always @(negedge clk) begin
      if (reset) begin
         tx_ack   = '0;
         man_seen = man_req;
         for (int k = 0; k < PC; k++) dly[k] = 0;
      end else begin
         for (int k = 0; k < PC; k++) begin
            if (man_req[k] != man_seen[k]) begin
               tx_ack[k]   = ~tx_ack[k];
               man_seen[k] = man_req[k];
            end else if (auto_ack && tx_req[k] != tx_ack[k]) begin
               if (dly[k] == 0) begin
                  tx_ack[k] = ~tx_ack[k];
                  dly[k]    = $urandom_range(0, 4);
               end else begin
                  dly[k]--;
               end
            end
         end
      end
   end

   // Monitor: pops the scoreboard on every request toggle, checks data.
   always @(negedge clk) begin
      logic [PC-1:0]      diff;
      logic [7:0]         e;
      logic [SIZE*PC-1:0] exp_data;
      int                 p;
      if (reset) begin
         prev_req = '0;
         prev_rd  = 1'b0;
         for (int k = 0; k < PC; k++) exp_slice[k] = '0;
      end else begin
         if (tx_req !== prev_req) begin
            diff = tx_req ^ prev_req;
            check("req_single_toggle", 64'($countones(diff)), 64'd1);
            if (exp_q.size() == 0) begin
               check("unexpected_send", 64'(diff), 64'd0);
            end else begin
               e = exp_q.pop_front();
               p = int'(e[7:5]);
               check("send_port", 64'(diff), 64'(1) << p);
               exp_slice[p] = e;
            end
            prev_req = tx_req;
         end
         for (int k = 0; k < PC; k++) exp_data[k*SIZE +: SIZE] = exp_slice[k];
         check("tx_data", 64'(tx_data), 64'(exp_data));
         if (fifo_read) begin
            check("read_nonempty", 64'(fifo_mem.size() > 0), 64'd1);
            check("read_one_cycle", 64'(prev_rd), 64'd0);
         end
         prev_rd = fifo_read;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] a, b, it;
      bit         found;

      // Reset state
      reset = 1'b1;
      repeat (3) tick();
      check("rst_fifo_read", 64'(fifo_read), 64'd0);
      check("rst_tx_req", 64'(tx_req), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_drop", 64'(drop_count), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      tick();

      // Scenario 1: 8'h45 to port 2, latency from empty falling
      push_item(8'h45);
      tick();
      check("t1_read_c1", 64'(fifo_read), 64'd1);
      check("t1_busy_c1", 64'(busy), 64'd1);
      tick();
      check("t1_read_c2", 64'(fifo_read), 64'd0);
      check("t1_req_c2", 64'(tx_req), 64'd0);
      tick();
      check("t1_req_c3", 64'(tx_req), 64'b00100);
      check("t1_data_c3", 64'(tx_data), 64'h00_00_45_00_00);

      // Scenario 2: ack two cycles after req, second item 8'h21 queued
      push_item(8'h21);
      tick();
      tick();
      ack_port(2);
      for (int i = 1; i <= ACK_LAT; i++) begin
         tick();
         check("t2_busy_after_ack", 64'(busy), (i == ACK_LAT) ? 64'd0 : 64'd1);
      end
      tick();
      check("t2_read", 64'(fifo_read), 64'd1);
      tick();
      tick();
      check("t2_req", 64'(tx_req), 64'b00110);
      check("t2_data", 64'(tx_data), 64'h00_00_45_21_00);
      ack_port(1);
      wait_idle(50);

      // Scenario 3a: invalid port drops the item
      push_item(8'hE0);
      wait_idle(50);
      check("t3_drop_one", 64'(drop_count), 64'(drop_model));
      check("t3_req_unchanged", 64'(tx_req), 64'b00110);

      // Scenario 4: two items for port 3, ack withheld for 10 cycles
      a = 8'h60 | 8'($urandom_range(0, 31));
      b = 8'h60 | 8'($urandom_range(0, 31));
      push_item(a);
      push_item(b);
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = tx_req[3];
      end
      check("t4_first_sent", 64'(found), 64'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("t4_req_hold", 64'(tx_req[3]), 64'd1);
         check("t4_slice_hold", 64'(tx_data[3*SIZE +: SIZE]), 64'(a));
      end
      ack_port(3);
      for (int i = 1; i <= ACK_LAT + 3; i++) begin
         tick();
         check("t4_second_req", 64'(tx_req[3]), (i == ACK_LAT + 3) ? 64'd0 : 64'd1);
      end
      check("t4_second_data", 64'(tx_data[3*SIZE +: SIZE]), 64'(b));
      ack_port(3);
      wait_idle(50);

      // Scenario 4b: spurious ack leaves port 0 pending, item waits in LATCH
      ack_port(0);
      a = 8'($urandom_range(0, 31));
      push_item(a);
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t4b_held", 64'(tx_req[0]), 64'd0);
      end
      ack_port(0);
      for (int i = 1; i <= ACK_LAT; i++) begin
         tick();
         check("t4b_release", 64'(tx_req[0]), (i == ACK_LAT) ? 64'd1 : 64'd0);
      end
      ack_port(0);
      wait_idle(50);

      // Random traffic with random-latency receivers
      auto_ack = 1'b1;
      for (int n = 0; n < 80; n++) begin
         it = 8'($urandom);
         push_item(it);
         repeat ($urandom_range(0, 6)) tick();
      end
      wait_idle(3000);
      check("rand_drop", 64'(drop_count), 64'(drop_model));

      // Saturation of drop_count
      for (int n = 0; n < 260; n++) begin
         it = {3'($urandom_range(5, 7)), 5'($urandom)};
         push_item(it);
      end
      wait_idle(5000);
      check("sat_drop", 64'(drop_count), 64'd255);
      check("sat_model", 64'(drop_count), 64'(drop_model));

      // Scenario 5: reset while in WAIT_ACK
      auto_ack = 1'b0;
      push_item(8'h80 | 8'($urandom_range(0, 31)));
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         found = (tx_req[4] != tx_ack[4]);
      end
      check("t5_sent", 64'(found), 64'd1);
      tick();
      reset = 1'b1;
      exp_q.delete();
      drop_model = 0;
      tick();
      check("t5_fifo_read", 64'(fifo_read), 64'd0);
      check("t5_tx_req", 64'(tx_req), 64'd0);
      check("t5_tx_data", 64'(tx_data), 64'd0);
      check("t5_drop", 64'(drop_count), 64'd0);
      check("t5_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("t5_no_reread", 64'(fifo_read), 64'd0);
         check("t5_idle", 64'(busy), 64'd0);
      end
      auto_ack = 1'b1;
      push_item(8'h40 | 8'($urandom_range(0, 31)));
      wait_idle(50);
      check("t5_final_drop", 64'(drop_count), 64'(drop_model));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
